// File: rtl/sonar_scheduler.sv
// ----------------------------------------------------------------------------
// sonar_scheduler: periodic trigger / wait / capture scheduler for a sonar sensor
// Revision 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sonar_scheduler #(
  parameter int unsigned MEDIR_LARGURA    = 5,
  parameter int unsigned TIMEOUT_CICLOS   = 1_500_000,
  parameter int unsigned INTERVALO_CICLOS = 5_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ligar,
  input  logic        pronto_in,
  input  logic [11:0] medida_in,
  output logic        medir,
  output logic        reset_sensor,
  output logic [11:0] dado,
  output logic        dado_valido,
  output logic        timeout,
  output logic [3:0]  falhas,
  output logic [3:0]  db_estado
);

  localparam int unsigned MAX_AB = (MEDIR_LARGURA > TIMEOUT_CICLOS) ? MEDIR_LARGURA : TIMEOUT_CICLOS;
  localparam int unsigned MAX_ALL = (MAX_AB > INTERVALO_CICLOS) ? MAX_AB : INTERVALO_CICLOS;
  localparam int unsigned CNT_W = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

  localparam logic [CNT_W-1:0] MEDIR_FIM     = CNT_W'(MEDIR_LARGURA - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_FIM   = CNT_W'(TIMEOUT_CICLOS - 1);
  localparam logic [CNT_W-1:0] INTERVALO_FIM = CNT_W'(INTERVALO_CICLOS - 1);

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    DISPARA   = 4'd1,
    ESPERA    = 4'd2,
    ARMAZENA  = 4'd3,
    FALHA     = 4'd4,
    INTERVALO = 4'd5
  } estado_t;

  estado_t          r_estado;
  logic [CNT_W-1:0] r_cnt;

  assign db_estado = r_estado;

  // Outputs are registered: each one is set on the edge that enters the
  // state it belongs to, so it is valid for that state's whole duration.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_estado     <= INICIAL;
      r_cnt        <= '0;
      medir        <= 1'b0;
      reset_sensor <= 1'b0;
      dado         <= 12'h000;
      dado_valido  <= 1'b0;
      timeout      <= 1'b0;
      falhas       <= 4'd0;
    end else begin
      medir        <= 1'b0;
      reset_sensor <= 1'b0;
      dado_valido  <= 1'b0;
      timeout      <= 1'b0;
      case (r_estado)
        INICIAL: begin
          r_cnt <= '0;
          if (ligar) begin
            r_estado <= DISPARA;
            medir    <= 1'b1;
          end
        end
        DISPARA: begin
          if (r_cnt == MEDIR_FIM) begin
            r_estado <= ESPERA;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            medir <= 1'b1;
          end
        end
        ESPERA: begin
          // A response on the final wait cycle still counts as success.
          if (pronto_in) begin
            r_estado    <= ARMAZENA;
            r_cnt       <= '0;
            dado        <= medida_in;
            dado_valido <= 1'b1;
          end else if (r_cnt == TIMEOUT_FIM) begin
            r_estado     <= FALHA;
            r_cnt        <= '0;
            timeout      <= 1'b1;
            reset_sensor <= 1'b1;
            if (falhas != 4'hF) falhas <= falhas + 4'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ARMAZENA, FALHA: begin
          r_estado <= INTERVALO;
          r_cnt    <= '0;
        end
        INTERVALO: begin
          if (!ligar) begin
            r_estado <= INICIAL;
            r_cnt    <= '0;
          end else if (r_cnt == INTERVALO_FIM) begin
            r_estado <= DISPARA;
            r_cnt    <= '0;
            medir    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_estado <= INICIAL;
          r_cnt    <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sonar_scheduler.sv
// ----------------------------------------------------------------------------
// tb_sonar_scheduler: randomized scoreboard bench for sonar_scheduler
// Revision 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_sonar_scheduler;
  localparam int unsigned W = 5;
  localparam int unsigned T = 50;
  localparam int unsigned I = 100;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ligar = 1'b0;
  logic        pronto_in = 1'b0;
  logic [11:0] medida_in = 12'h000;
  logic        medir, reset_sensor, dado_valido, timeout;
  logic [11:0] dado;
  logic [3:0]  falhas, db_estado;

  sonar_scheduler #(
    .MEDIR_LARGURA(W), .TIMEOUT_CICLOS(T), .INTERVALO_CICLOS(I)
  ) dut (
    .clock(clock), .reset(reset), .ligar(ligar), .pronto_in(pronto_in),
    .medida_in(medida_in), .medir(medir), .reset_sensor(reset_sensor),
    .dado(dado), .dado_valido(dado_valido), .timeout(timeout),
    .falhas(falhas), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit          to;
    logic [11:0] d;
    logic [3:0]  f;
    int unsigned at;
  } exp_t;
  exp_t sb[$];

  logic [11:0] dado_m = 12'h000;
  logic [3:0]  falhas_m = 4'd0;
  int unsigned exp_rise = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic finish_run;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // Monitor: every completion pulse is matched against the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset && (dado_valido || timeout)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got valido=%0b timeout=%0b, expected none (cycle %0d)",
                 dado_valido, timeout, cyc);
      end else begin
        e = sb.pop_front();
        chk("event_cycle", cyc, e.at);
        chk("timeout", timeout, e.to);
        chk("reset_sensor", reset_sensor, e.to);
        chk("dado_valido", dado_valido, !e.to);
        chk("dado", dado, e.d);
        chk("falhas", falhas, e.f);
      end
    end
  end

  task automatic wait_rise(input int unsigned budget, output int unsigned r, output bit ok);
    ok = 1'b0;
    r  = 0;
    for (int unsigned k = 0; k < budget; k++) begin
      @(negedge clock);
      if (medir) begin
        r  = cyc;
        ok = 1'b1;
        return;
      end
    end
  endtask

  // One measurement: sensor answers d cycles after medir falls, or never (to=1).
  task automatic measure(input bit to, input int unsigned d, input logic [11:0] val, input bit drop);
    int unsigned r, f, e, n;
    bit ok, quiet;
    wait_rise(T + I + 20, r, ok);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL medir_rise: got no rise, expected rise at cycle %0d", exp_rise);
      finish_run();
    end
    chk("rise_cycle", r, exp_rise);
    chk("db_dispara", db_estado, 1);
    if ($urandom_range(0, 1) == 1) begin
      pronto_in = 1'b1;
      medida_in = 12'($urandom());
    end
    n = 0;
    while (medir && n < W + 5) begin
      n++;
      @(negedge clock);
      pronto_in = 1'b0;
    end
    f = cyc;
    chk("medir_width", n, W);
    chk("db_espera", db_estado, 2);
    if (drop) ligar = 1'b0;
    if (to) begin
      falhas_m = (falhas_m == 4'd15) ? 4'd15 : falhas_m + 4'd1;
      e = f + T;
      sb.push_back('{1'b1, dado_m, falhas_m, e});
    end else begin
      dado_m = val;
      e = f + d + 1;
      sb.push_back('{1'b0, dado_m, falhas_m, e});
      repeat (d) @(negedge clock);
      pronto_in = 1'b1;
      medida_in = val;
      @(negedge clock);
      pronto_in = 1'b0;
      medida_in = 12'($urandom());
    end
    if (!drop) begin
      exp_rise = e + 1 + I;
    end else begin
      while (cyc < e + 2) @(negedge clock);
      chk("db_inicial_after_drop", db_estado, 0);
      quiet = 1'b1;
      repeat ($urandom_range(3, 30)) begin
        @(negedge clock);
        if (medir || db_estado != 4'd0) quiet = 1'b0;
      end
      chk("stays_idle", quiet, 1);
      ligar = 1'b1;
      exp_rise = cyc + 1;
    end
  endtask

  initial begin
    int unsigned r;
    bit ok;
    repeat (3) begin
      @(negedge clock);
      pronto_in = ~pronto_in;
      medida_in = 12'($urandom());
    end
    pronto_in = 1'b0;
    chk("rst_medir", medir, 0);
    chk("rst_reset_sensor", reset_sensor, 0);
    chk("rst_dado", dado, 0);
    chk("rst_dado_valido", dado_valido, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_falhas", falhas, 0);
    chk("rst_db_estado", db_estado, 0);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    chk("idle_db", db_estado, 0);
    chk("idle_medir", medir, 0);
    ligar = 1'b1;
    exp_rise = cyc + 1;

    measure(1'b0, 20, 12'h100, 1'b0);
    measure(1'b1, 0, 12'h000, 1'b0);
    measure(1'b0, T - 1, 12'h075, 1'b0);
    for (int i = 0; i < 20; i++) begin
      int unsigned kind;
      int unsigned d;
      kind = $urandom_range(0, 3);
      d = (kind == 1) ? (($urandom_range(0, 1) == 1) ? T - 1 : 0) : $urandom_range(0, T - 1);
      measure(kind == 0, d, 12'($urandom()), $urandom_range(0, 5) == 0);
    end
    repeat (17) measure(1'b1, 0, 12'h000, 1'b0);
    measure(1'b1, 0, 12'h000, 1'b1);
    measure(1'b0, $urandom_range(0, T - 1), 12'($urandom()), 1'b1);

    // Reset pulse in the middle of a trigger pulse.
    wait_rise(T + I + 20, r, ok);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL medir_rise: got no rise, expected rise at cycle %0d", exp_rise);
      finish_run();
    end
    chk("rise_cycle", r, exp_rise);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("midrst_medir", medir, 0);
    chk("midrst_db", db_estado, 0);
    chk("midrst_dado", dado, 0);
    chk("midrst_falhas", falhas, 0);
    chk("midrst_timeout", timeout, 0);
    dado_m   = 12'h000;
    falhas_m = 4'd0;
    exp_rise = cyc + 1;
    measure(1'b1, 0, 12'h000, 1'b0);
    measure(1'b0, $urandom_range(0, T - 1), 12'($urandom()), 1'b0);

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", sb.size(), 0);
    finish_run();
  end

  initial begin
    #600000;
    total++;
    bad++;
    $display("FAIL watchdog: got no finish, expected finish within 60000 cycles");
    finish_run();
  end

endmodule

`default_nettype wire

// File: doc/sonar_scheduler.md
SONAR_SCHEDULER -- requirements
Module: sonar_scheduler

Parameters
REQ-001 MEDIR_LARGURA, default 5: clock cycles that medir is held high per measurement request.
REQ-002 TIMEOUT_CICLOS, default 1_500_000: maximum wait for pronto_in after medir falls (30 ms at 50 MHz).
REQ-003 INTERVALO_CICLOS, default 5_000_000: idle cycles between end of one measurement and next request (100 ms at 50 MHz).

Interface
REQ-004 clock  in  1  system clock (50 MHz); all state changes on rising edge.
REQ-005 reset  in  1  reset, synchronous and active-low (0 = reset, sampled on rising edge of clock).
REQ-006 ligar  in  1  level; 1 enables periodic measurement, 0 stops after current measurement.
REQ-007 pronto_in  in  1  measurement-done pulse from sensor interface.
REQ-008 medida_in  in  12  BCD distance (3 digits, cm) from sensor interface, valid when pronto_in=1.
REQ-009 medir  out  1  measurement request to sensor interface.
REQ-010 reset_sensor  out  1  one-cycle active-high reset pulse to sensor interface after timeout.
REQ-011 dado  out  12  last successfully captured distance.
REQ-012 dado_valido  out  1  one-cycle pulse when dado is updated.
REQ-013 timeout  out  1  one-cycle pulse on measurement timeout.
REQ-014 falhas  out  4  count of timeouts, saturating.
REQ-015 db_estado  out  4  current FSM state code.

Function
REQ-016 FSM states/codes: INICIAL=0, DISPARA=1, ESPERA=2, ARMAZENA=3, FALHA=4, INTERVALO=5; unused codes return to INICIAL next cycle.
REQ-017 INICIAL: all pulse outputs 0; ligar=1 -> DISPARA next cycle; else stay.
REQ-018 DISPARA: medir=1 for exactly MEDIR_LARGURA consecutive cycles, then -> ESPERA; medir=0 in every other state.
REQ-019 ESPERA: one cycle counter runs from 0; pronto_in=1 -> ARMAZENA; else counter = TIMEOUT_CICLOS-1 -> FALHA.
REQ-020 pronto_in=1 on the same cycle the counter reaches TIMEOUT_CICLOS-1: pronto wins, go to ARMAZENA.
REQ-021 dado is loaded with medida_in on the edge where ESPERA sees pronto_in=1; dado_valido=1 during the single ARMAZENA cycle; ARMAZENA -> INTERVALO.
REQ-022 FALHA (one cycle): timeout=1, reset_sensor=1, falhas += 1 saturating at 15, dado unchanged; -> INTERVALO.
REQ-023 INTERVALO: counter runs from 0; ligar=0 on any cycle -> INICIAL; counter = INTERVALO_CICLOS-1 with ligar=1 -> DISPARA.
REQ-024 ligar falling during DISPARA/ESPERA does not abort; measurement completes (ARMAZENA or FALHA), then INTERVALO exits to INICIAL.
REQ-025 pronto_in ignored in every state except ESPERA; medida_in never sampled outside that edge.
REQ-026 Counters are cleared on every state entry; sized by $clog2 of largest parameter; no wrap possible within a state.

Reset
REQ-027 reset=0 at a rising edge, in any state including mid-measurement: state INICIAL, medir=0, reset_sensor=0, dado=0, dado_valido=0, timeout=0, falhas=0, db_estado=0, counters 0.
REQ-028 While reset=0, all inputs ignored; first active cycle after reset=1 evaluates ligar from INICIAL.

Verification (MEDIR_LARGURA=5, TIMEOUT_CICLOS=50, INTERVALO_CICLOS=100)
REQ-029 ligar=1 after reset -> medir high exactly 5 cycles starting 1 cycle later; db_estado 0->1->2.
REQ-030 pronto_in pulse 20 cycles after medir falls, medida_in=12'h100 -> dado=12'h100, dado_valido one cycle, falhas=0, next medir rises 100 cycles after ARMAZENA+1.
REQ-031 no pronto_in -> timeout and reset_sensor one-cycle pulse 50 cycles after medir falls; falhas=1; dado keeps previous value.
REQ-032 pronto_in on the 50th ESPERA cycle with medida_in=12'h075 -> dado=12'h075, no timeout pulse, falhas unchanged.
REQ-033 16 consecutive timeouts -> falhas stays 15; ligar=0 during ESPERA -> measurement completes, then db_estado=0 and medir stays 0.
REQ-034 reset=0 for one cycle during DISPARA with medir=1 -> next cycle medir=0, db_estado=0, dado=0, falhas=0.
